serial_adder: RTL and testbench

- Bit-serial WIDTH-bit adder. It instantiates the existing FullAdder cell (ports a, b, cin, s, cout) once and adds one bit per clock.
- A carry flip-flop feeds cout back into cin between bits.
- It is the sequential stage built on the single-bit FullAdder and trades latency for area.
- Operands load in parallel on start. Result is presented in parallel with a one-cycle done pulse.

---
 rtl/serial_adder.sv | 106 ++++++++++
 tb/tb_serial_adder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one FullAdder cell reused once per clock, with a
// carry flop closing the loop between bits. FullAdder is the existing 1-bit cell.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       state_dbg
);
  localparam int CW = $clog2(WIDTH) + 1;

  // Handshake: start is a level sampled only while IDLE; the edge that sees it
  // loads a/b/cin. done is a single-cycle pulse and sum/cout are valid with it.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [WIDTH-1:0] reg_a, reg_b, res, res_next;
  logic [CW-1:0]    cnt;
  logic             carry, fa_s, fa_cout, last_bit;

  FullAdder u_fa (
    .a    (reg_a[0]),
    .b    (reg_b[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
  assign res_next  = (res >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
  assign last_bit  = (cnt == CW'(WIDTH - 1));
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      reg_a <= '0;
      reg_b <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            reg_a <= a;
            reg_b <= b;
            carry <= cin;
            res   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          carry <= fa_cout;
          reg_a <= reg_a >> 1;
          reg_b <= reg_b >> 1;
          res   <= res_next;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            sum   <= res_next;
            cout  <= fa_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// Single-bit full adder cell.
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for timing/arithmetic
// scenarios and a 1-bit instance walked through the full-adder truth table.
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout;
  logic [7:0] sum;
  logic [1:0] state_dbg;

  logic       start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;
  logic [1:0] state_dbg1;

  int tests = 0;
  int fails = 0;

  // {cout,sum} for {a,b,cin} = 0..7
  logic [1:0] fa_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .state_dbg(state_dbg)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .state_dbg(state_dbg1)
  );

  // Advance past the next rising edge; outputs have settled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise start for exactly one accepting edge.
  task automatic kick(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    a = va; b = vb; cin = vc; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    tests++;
    if ({busy, done, cout, sum, state_dbg} !== 13'd0) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b cout=%b sum=%0d state=%0d, want all 0",
               busy, done, cout, sum, state_dbg);
    end
  endtask

  task automatic test_basic();
    int bad_run = 0;
    kick(8'd3, 8'd5, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      if (busy !== 1'b1 || done !== 1'b0 || sum !== 8'd0) bad_run++;
      step();
    end
    tests++;
    if (bad_run != 0) begin
      fails++;
      $display("FAIL basic_busy_window: %0d bad cycles in k+1..k+8, want 0", bad_run);
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || sum !== 8'd8 || cout !== 1'b0) begin
      fails++;
      $display("FAIL basic_done: done=%b busy=%b sum=%0d cout=%b, want 1 0 8 0",
               done, busy, sum, cout);
    end
    step();
    tests++;
    if (done !== 1'b0 || state_dbg !== 2'd0) begin
      fails++;
      $display("FAIL basic_pulse_width: done=%b state=%0d, want 0 0", done, state_dbg);
    end
  endtask

  task automatic test_carry();
    int bad_hold = 0;
    kick(8'd255, 8'd1, 1'b0);
    repeat (8) step();
    tests++;
    if (done !== 1'b1 || sum !== 8'd0 || cout !== 1'b1) begin
      fails++;
      $display("FAIL carry_overflow: done=%b sum=%0d cout=%b, want 1 0 1", done, sum, cout);
    end
    step();
    kick(8'd255, 8'd255, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      if (sum !== 8'd0 || cout !== 1'b1 || done !== 1'b0) bad_hold++;
      step();
    end
    tests++;
    if (bad_hold != 0) begin
      fails++;
      $display("FAIL carry_hold: %0d cycles exposed a new result early, want 0", bad_hold);
    end
    tests++;
    if (done !== 1'b1 || sum !== 8'd255 || cout !== 1'b1) begin
      fails++;
      $display("FAIL carry_max: done=%b sum=%0d cout=%b, want 1 255 1", done, sum, cout);
    end
    step();
  endtask

  task automatic test_start_ignored();
    kick(8'd10, 8'd20, 1'b0);
    a = 8'd100; b = 8'd100; start = 1'b1;
    repeat (8) step();
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || sum !== 8'd30) begin
      fails++;
      $display("FAIL ignore_first: done=%b busy=%b sum=%0d, want 1 0 30", done, busy, sum);
    end
    step();
    tests++;
    if (busy !== 1'b0 || state_dbg !== 2'd0) begin
      fails++;
      $display("FAIL ignore_in_done: busy=%b state=%0d, want 0 0", busy, state_dbg);
    end
    step();
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL ignore_accept: busy=%b, want 1", busy);
    end
    repeat (8) step();
    tests++;
    if (done !== 1'b1 || sum !== 8'd200 || cout !== 1'b0) begin
      fails++;
      $display("FAIL ignore_second: done=%b sum=%0d cout=%b, want 1 200 0", done, sum, cout);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int seen_done = 0;
    kick(8'd200, 8'd100, 1'b0);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'd0 || cout !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: busy=%b done=%b sum=%0d cout=%b, want 0 0 0 0",
               busy, done, sum, cout);
    end
    for (int i = 0; i < 12; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) seen_done++;
      step();
    end
    tests++;
    if (seen_done != 0) begin
      fails++;
      $display("FAIL reset_mid_quiet: %0d cycles with done/busy after abort, want 0", seen_done);
    end
  endtask

  task automatic test_reset_vs_start();
    a = 8'd1; b = 8'd1; cin = 1'b0;
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    tests++;
    if (busy !== 1'b0 || state_dbg !== 2'd0) begin
      fails++;
      $display("FAIL reset_wins: busy=%b state=%0d, want 0 0", busy, state_dbg);
    end
    repeat (3) step();
  endtask

  task automatic test_back_to_back_w1();
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      step();
      start1 = 1'b0;
      tests++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        fails++;
        $display("FAIL w1_busy[%0d]: busy=%b done=%b, want 1 0", i, busy1, done1);
      end
      step();
      tests++;
      if (done1 !== 1'b1 || {cout1, sum1} !== fa_tab[i]) begin
        fails++;
        $display("FAIL w1_sum[%0d]: done=%b cout_sum=%b, want 1 %b", i, done1, {cout1, sum1}, fa_tab[i]);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_start_ignored();
    test_reset_mid();
    test_reset_vs_start();
    test_back_to_back_w1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
